sobel_frame_scheduler: RTL and testbench
========================================

Name: sobel_frame_scheduler

Overview:
Sequences a full grayscale frame through the 3x3 Sobel window engine (sobel_control). Walks the image in vertical 3-pixel-wide strips: fetches pixels from a frame-buffer read port, feeds them to the engine in its load order (9 pixels to prime a window, then 3 per downward slide), and resets the engine between strips. Tags each returned gradient pixel with its (x,y) centre coordinate for the writer, and signals frame completion.

Parameters:
ADDR_W, 24, frame-buffer pixel address width
DIM_W, 12, width of the width/height/coordinate fields
PIXEL_W, 8, pixel width

Ports:
clk_i  in  1  clock
nreset_i  in  1  asynchronous active-low reset
start_i  in  1  pulse: begin frame (ignored while busy_o=1)
abort_i  in  1  pulse: abandon frame
cfg_width_i  in  DIM_W  image width W, sampled on accepted start
cfg_height_i  in  DIM_W  image height H, sampled on accepted start
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse at frame end
cfg_err_o  out  1  sticky until next accepted start: W<3 or H<3
rd_req_o  out  1  read request, held until rd_valid_i
rd_addr_o  out  ADDR_W  pixel address y*W+x, stable while rd_req_o=1
rd_valid_i  in  1  read data valid this cycle (completes request)
rd_data_i  in  PIXEL_W  read data
sobel_nreset_o  out  1  registered active-low engine reset
sobel_start_o  out  1  engine start, held high through a strip
sobel_px_o  out  PIXEL_W  pixel to engine
sobel_px_rdy_o  out  1  one-cycle pixel strobe to engine
sobel_res_rdy_i  in  1  engine result valid
sobel_res_px_i  in  PIXEL_W  engine result
out_valid_o  out  1  one-cycle result strobe
out_px_o  out  PIXEL_W  gradient pixel
out_x_o  out  DIM_W  result column
out_y_o  out  DIM_W  result row

Behaviour:
- Reset: all outputs 0 except sobel_nreset_o=1; state IDLE; counters 0.
- States: IDLE, CLR, ARM, FETCH, PUSH, DRAIN, DONE.
- IDLE: start_i -> latch W,H, clear cfg_err_o. If W<3 or H<3: set cfg_err_o, go DONE (no reads). Else strip c=0, go CLR. busy_o=1 in every state except IDLE.
- CLR: sobel_nreset_o=0 for exactly one cycle, sobel_start_o=0 -> ARM.
- ARM: sobel_start_o<=1 (held until next CLR/abort); row r=0, row_base=0, group size 9 -> FETCH.
- FETCH: rd_req_o=1, rd_addr_o=row_base+c+k (k=0..2). On rd_valid_i: sobel_px_o<=rd_data_i -> PUSH. No multiplier: row_base += W after each row's k=2.
- PUSH: sobel_px_rdy_o=1 for one cycle. Priming group order: rows 0,1,2 x cols c..c+2, row-major. Then one 3-pixel group per row r=3..H-1. After last pixel of a group: outstanding+=1. More pixels -> FETCH; last pixel of row H-1 -> DRAIN.
- Throughput: 2 cycles/pixel minimum (rd_valid_i same cycle as request).
- outstanding decrements on sobel_res_rdy_i; simultaneous inc/dec leaves it unchanged. Width 2 bits is sufficient.
- DRAIN: wait outstanding==0. Then c==W-3 -> DONE; else c+=1 -> CLR.
- DONE: frame_done_o=1 one cycle, sobel_start_o=0 -> IDLE.
- Results (registered, 1 cycle after sobel_res_rdy_i): out_valid_o=1, out_px_o=sobel_res_px_i, out_x_o=c+1, out_y_o increments from 1 per result and reloads to 1 at CLR. A frame yields exactly (W-2)*(H-2) results, strip-major order.
- abort_i (any non-IDLE state, wins over all events): next cycle rd_req_o=0, sobel_start_o=0, sobel_nreset_o=0 one cycle, then IDLE. No frame_done_o; late engine results are dropped.
- Async reset mid-frame: immediate return to reset values. An in-flight read is abandoned.

Decomposition:
- Shared package: PIXEL_W, ADDR_W, DIM_W, state enum, priming count 9, slide count 3.
- One sub-module, sobel_addr_gen: row_base/column/k counters and rd_addr_o generation, with strip-start and next-pixel controls.

Test Plan:
- 4x4 frame, mem[a]=a, rd_valid_i same cycle -> addresses 0,1,2,4,5,6,8,9,10,12,13,14 | CLR | 1,2,3,5,6,7,9,10,11,13,14,15. Outputs at (1,1),(1,2),(2,1),(2,2) match a golden Sobel model; one frame_done_o.
- 5x6 flat image 0x80 -> 12 results, all 0x00; sobel_nreset_o low for exactly 3 single cycles (frame start plus 2 strip changes).
- cfg 2x5 -> cfg_err_o=1, frame_done_o 2 cycles after start, rd_req_o never asserted; next start with 4x4 clears cfg_err_o.
- Random 0-5 cycle rd_valid_i delay on 8x8 -> identical address sequence and results to zero-delay run; rd_addr_o stable while rd_req_o=1.
- abort_i mid strip 1 of 6x6 -> rd_req_o=0 next cycle, one-cycle sobel_nreset_o low, busy_o=0, no frame_done_o. A following start completes the full 16 results.
- start_i during busy -> ignored, result count unchanged. nreset_i low mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sobel_frame_scheduler_pkg.sv
// Shared widths, window load counts and FSM encoding for the Sobel frame scheduler.
package sobel_frame_scheduler_pkg;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DIM_W   = 12;
    localparam int DEF_PIXEL_W = 8;

    localparam int PRIME_CNT = 9;
    localparam int SLIDE_CNT = 3;
    localparam int GRP_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ARM,
        ST_FETCH,
        ST_PUSH,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/sobel_frame_scheduler_addr_gen.sv
// Strip walker: column, row and in-row offset counters producing y*W+x without a multiplier.
module sobel_addr_gen
    import sobel_frame_scheduler_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input  logic              clk_i,
    input  logic              nreset_i,
    input  logic [DIM_W-1:0]  width_i,
    input  logic              col_init_i,
    input  logic              col_inc_i,
    input  logic              row_clr_i,
    input  logic              px_adv_i,
    output logic [DIM_W-1:0]  col_o,
    output logic [DIM_W-1:0]  row_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [1:0]        k_q, k_d;

    always_comb begin
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        k_d        = k_q;

        if (col_init_i) begin
            col_d = '0;
        end else if (col_inc_i) begin
            col_d = col_q + DIM_W'(1);
        end

        // The base of the next image row is accumulated once per completed 3-pixel row.
        if (row_clr_i) begin
            row_base_d = '0;
            row_d      = '0;
            k_d        = '0;
        end else if (px_adv_i) begin
            if (k_q == 2'd2) begin
                k_d        = '0;
                row_d      = row_q + DIM_W'(1);
                row_base_d = row_base_q + ADDR_W'(width_i);
            end else begin
                k_d = k_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            row_base_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            k_q        <= '0;
        end else begin
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
            k_q        <= k_d;
        end
    end

    assign col_o     = col_q;
    assign row_o     = row_q;
    assign rd_addr_o = row_base_q + ADDR_W'(col_q) + ADDR_W'(k_q);

endmodule

// File: rtl/sobel_frame_scheduler.sv
// Walks a frame in 3-pixel-wide vertical strips, feeding the 3x3 Sobel engine and tagging its results.
module sobel_frame_scheduler
    import sobel_frame_scheduler_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DIM_W   = DEF_DIM_W,
    parameter int PIXEL_W = DEF_PIXEL_W
) (
    input  logic               clk_i,
    input  logic               nreset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [DIM_W-1:0]   cfg_width_i,
    input  logic [DIM_W-1:0]   cfg_height_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               cfg_err_o,
    output logic               rd_req_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic               rd_valid_i,
    input  logic [PIXEL_W-1:0] rd_data_i,
    output logic               sobel_nreset_o,
    output logic               sobel_start_o,
    output logic [PIXEL_W-1:0] sobel_px_o,
    output logic               sobel_px_rdy_o,
    input  logic               sobel_res_rdy_i,
    input  logic [PIXEL_W-1:0] sobel_res_px_i,
    output logic               out_valid_o,
    output logic [PIXEL_W-1:0] out_px_o,
    output logic [DIM_W-1:0]   out_x_o,
    output logic [DIM_W-1:0]   out_y_o
);

    sched_state_t       state_q, state_d;
    logic [DIM_W-1:0]   w_q, w_d;
    logic [DIM_W-1:0]   h_q, h_d;
    logic               cfg_err_q, cfg_err_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [1:0]         outst_q, outst_d;
    logic [DIM_W-1:0]   y_q, y_d;
    logic               snrst_q, snrst_d;
    logic               sstart_q, sstart_d;
    logic               done_q, done_d;
    logic [PIXEL_W-1:0] px_q;
    logic               px_rdy_q;
    logic               out_valid_q;
    logic [PIXEL_W-1:0] out_px_q;
    logic [DIM_W-1:0]   out_x_q, out_y_q;

    logic               col_init, col_inc, row_clr, px_adv;
    logic               grp_inc, grp_dec;
    logic               px_load, res_acc;
    logic [DIM_W-1:0]   col, row;

    sobel_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .width_i    (w_q),
        .col_init_i (col_init),
        .col_inc_i  (col_inc),
        .row_clr_i  (row_clr),
        .px_adv_i   (px_adv),
        .col_o      (col),
        .row_o      (row),
        .rd_addr_o  (rd_addr_o)
    );

    assign px_load = (state_q == ST_FETCH) && rd_valid_i && !abort_i;
    assign res_acc = sobel_res_rdy_i && (state_q != ST_IDLE) && !abort_i;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        h_d       = h_q;
        cfg_err_d = cfg_err_q;
        grp_d     = grp_q;
        outst_d   = outst_q;
        y_d       = y_q;
        snrst_d   = 1'b1;
        sstart_d  = sstart_q;
        done_d    = 1'b0;
        col_init  = 1'b0;
        col_inc   = 1'b0;
        row_clr   = 1'b0;
        px_adv    = 1'b0;
        grp_inc   = 1'b0;
        grp_dec   = res_acc && (outst_q != 2'd0);

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    w_d      = cfg_width_i;
                    h_d      = cfg_height_i;
                    col_init = 1'b1;
                    if ((cfg_width_i < DIM_W'(3)) || (cfg_height_i < DIM_W'(3))) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        cfg_err_d = 1'b0;
                        state_d   = ST_CLR;
                    end
                end
            end
            ST_CLR: begin
                snrst_d  = 1'b0;
                sstart_d = 1'b0;
                y_d      = DIM_W'(1);
                state_d  = ST_ARM;
            end
            ST_ARM: begin
                sstart_d = 1'b1;
                row_clr  = 1'b1;
                grp_d    = GRP_W'(PRIME_CNT);
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                if (rd_valid_i) begin
                    state_d = ST_PUSH;
                end
            end
            ST_PUSH: begin
                px_adv = 1'b1;
                // The last pixel of a group completes a window; one result is now owed.
                if (grp_q == GRP_W'(1)) begin
                    grp_inc = 1'b1;
                    grp_d   = GRP_W'(SLIDE_CNT);
                    state_d = (row == h_q - DIM_W'(1)) ? ST_DRAIN : ST_FETCH;
                end else begin
                    grp_d   = grp_q - GRP_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (outst_q == 2'd0) begin
                    if (col == w_q - DIM_W'(3)) begin
                        state_d = ST_DONE;
                    end else begin
                        col_inc = 1'b1;
                        state_d = ST_CLR;
                    end
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                sstart_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        unique case ({grp_inc, grp_dec})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase

        if (res_acc) begin
            y_d = y_q + DIM_W'(1);
        end

        // Abort overrides every other event in the cycle it is seen.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            snrst_d  = 1'b0;
            sstart_d = 1'b0;
            done_d   = 1'b0;
            outst_d  = 2'd0;
            col_init = 1'b0;
            col_inc  = 1'b0;
            row_clr  = 1'b0;
            px_adv   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q   <= ST_IDLE;
            w_q       <= '0;
            h_q       <= '0;
            cfg_err_q <= 1'b0;
            grp_q     <= '0;
            outst_q   <= '0;
            y_q       <= '0;
            snrst_q   <= 1'b1;
            sstart_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            h_q       <= h_d;
            cfg_err_q <= cfg_err_d;
            grp_q     <= grp_d;
            outst_q   <= outst_d;
            y_q       <= y_d;
            snrst_q   <= snrst_d;
            sstart_q  <= sstart_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            px_q        <= '0;
            px_rdy_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_px_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            px_rdy_q    <= px_load;
            out_valid_q <= res_acc;
            if (px_load) begin
                px_q <= rd_data_i;
            end
            if (res_acc) begin
                out_px_q <= sobel_res_px_i;
                out_x_q  <= col + DIM_W'(1);
                out_y_q  <= y_q;
            end
        end
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign rd_req_o       = (state_q == ST_FETCH);
    assign frame_done_o   = done_q;
    assign cfg_err_o      = cfg_err_q;
    assign sobel_nreset_o = snrst_q;
    assign sobel_start_o  = sstart_q;
    assign sobel_px_o     = px_q;
    assign sobel_px_rdy_o = px_rdy_q;
    assign out_valid_o    = out_valid_q;
    assign out_px_o       = out_px_q;
    assign out_x_o        = out_x_q;
    assign out_y_o        = out_y_q;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench: frame-buffer responder, behavioural 3x3 Sobel engine and result/address scoreboards.
`timescale 1ns/1ps
module tb_sobel_frame_scheduler;

    localparam int ADDR_W  = 24;
    localparam int DIM_W   = 12;
    localparam int PIXEL_W = 8;

    logic               clk = 1'b0;
    logic               nreset_i, start_i, abort_i;
    logic [DIM_W-1:0]   cfg_width_i, cfg_height_i;
    logic               busy_o, frame_done_o, cfg_err_o;
    logic               rd_req_o, rd_valid_i;
    logic [ADDR_W-1:0]  rd_addr_o;
    logic [PIXEL_W-1:0] rd_data_i;
    logic               sobel_nreset_o, sobel_start_o, sobel_px_rdy_o;
    logic [PIXEL_W-1:0] sobel_px_o;
    logic               sobel_res_rdy_i;
    logic [PIXEL_W-1:0] sobel_res_px_i;
    logic               out_valid_o;
    logic [PIXEL_W-1:0] out_px_o;
    logic [DIM_W-1:0]   out_x_o, out_y_o;

    always #5 clk = ~clk;

    sobel_frame_scheduler dut (
        .clk_i           (clk),
        .nreset_i        (nreset_i),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .cfg_width_i     (cfg_width_i),
        .cfg_height_i    (cfg_height_i),
        .busy_o          (busy_o),
        .frame_done_o    (frame_done_o),
        .cfg_err_o       (cfg_err_o),
        .rd_req_o        (rd_req_o),
        .rd_addr_o       (rd_addr_o),
        .rd_valid_i      (rd_valid_i),
        .rd_data_i       (rd_data_i),
        .sobel_nreset_o  (sobel_nreset_o),
        .sobel_start_o   (sobel_start_o),
        .sobel_px_o      (sobel_px_o),
        .sobel_px_rdy_o  (sobel_px_rdy_o),
        .sobel_res_rdy_i (sobel_res_rdy_i),
        .sobel_res_px_i  (sobel_res_px_i),
        .out_valid_o     (out_valid_o),
        .out_px_o        (out_px_o),
        .out_x_o         (out_x_o),
        .out_y_o         (out_y_o)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [7:0] mem [0:255];
    int addr_log[$];
    int ref_log[$];
    int res_x[$], res_y[$], res_px[$];
    int n_done, n_nrst_low, n_rdreq, n_stab_err;
    bit rand_delay = 1'b0;
    int wait_cnt = 0;
    bit req_hold = 1'b0;
    logic [ADDR_W-1:0] hold_addr;

    int eng_pc = 0;
    int ecyc = 0;
    int slot;
    logic [71:0] win = '0;
    int due_q[$];
    logic [7:0] val_q[$];

    int exp_addr4 [24] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14,
                           1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // |Gx|+|Gy| saturated to 8 bits; window byte i is row i/3, column i%3.
    function automatic logic [7:0] sobel_win(input logic [71:0] w);
        int p [9];
        int gx, gy, m;
        for (int i = 0; i < 9; i++) p[i] = int'(w[8*i +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'hFF : m[7:0];
    endfunction

    function automatic logic [7:0] px_at(input int a);
        return mem[a[7:0]];
    endfunction

    function automatic logic [7:0] golden(input int w, input int x, input int y);
        logic [71:0] g;
        g = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                g[8*(dy*3+dx) +: 8] = px_at((y-1+dy)*w + (x-1+dx));
        return sobel_win(g);
    endfunction

    // Monitor: counts strobes and captures results away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done_o) n_done++;
            if (!sobel_nreset_o) n_nrst_low++;
            if (rd_req_o) begin
                n_rdreq++;
                if (req_hold && rd_addr_o != hold_addr) n_stab_err++;
                req_hold  = 1'b1;
                hold_addr = rd_addr_o;
            end else begin
                req_hold = 1'b0;
            end
            if (out_valid_o) begin
                res_x.push_back(int'(out_x_o));
                res_y.push_back(int'(out_y_o));
                res_px.push_back(int'(out_px_o));
            end
        end
    end

    // Frame-buffer read port with optional random latency.
    initial begin
        rd_valid_i = 1'b0;
        rd_data_i  = '0;
        forever begin
            @(negedge clk);
            rd_valid_i = 1'b0;
            if (rd_req_o && nreset_i) begin
                if (wait_cnt == 0) begin
                    rd_valid_i = 1'b1;
                    rd_data_i  = mem[rd_addr_o[7:0]];
                    addr_log.push_back(int'(rd_addr_o));
                    wait_cnt = rand_delay ? int'($urandom_range(0, 5)) : 0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Engine model: 9 pixels prime the window, each further 3 slide it down; result 3 cycles later.
    initial begin
        sobel_res_rdy_i = 1'b0;
        sobel_res_px_i  = '0;
        forever begin
            @(negedge clk);
            ecyc++;
            sobel_res_rdy_i = 1'b0;
            if (!nreset_i) begin
                eng_pc = 0;
                due_q.delete();
                val_q.delete();
            end else begin
                if (due_q.size() > 0 && due_q[0] <= ecyc) begin
                    sobel_res_rdy_i = 1'b1;
                    sobel_res_px_i  = val_q.pop_front();
                    void'(due_q.pop_front());
                end
                if (!sobel_nreset_o) begin
                    eng_pc = 0;
                end else if (sobel_px_rdy_o && sobel_start_o) begin
                    if (eng_pc < 9) begin
                        win[8*eng_pc +: 8] = sobel_px_o;
                        eng_pc++;
                        if (eng_pc == 9) begin
                            due_q.push_back(ecyc + 3);
                            val_q.push_back(sobel_win(win));
                        end
                    end else begin
                        slot = (eng_pc - 9) % 3;
                        if (slot == 0) win = {24'h0, win[71:24]};
                        win[48 + 8*slot +: 8] = sobel_px_o;
                        eng_pc++;
                        if (slot == 2) begin
                            due_q.push_back(ecyc + 3);
                            val_q.push_back(sobel_win(win));
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        res_x.delete();
        res_y.delete();
        res_px.delete();
        n_done     = 0;
        n_nrst_low = 0;
        n_rdreq    = 0;
        n_stab_err = 0;
    endtask

    task automatic start_frame(input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h);
        cfg_width_i  = w;
        cfg_height_i = h;
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int t;
        t = 0;
        while (n_done == 0 && t < budget) begin
            tick();
            t++;
        end
        repeat (10) tick();
        check({tag, " frame_done count"}, n_done, 1);
    endtask

    task automatic check_results(input int w, input int h, input string tag);
        int n;
        n = (w-2) * (h-2);
        check({tag, " result count"}, res_x.size(), n);
        for (int i = 0; i < res_x.size() && i < n; i++) begin
            int ex;
            int ey;
            ex = 1 + i / (h-2);
            ey = 1 + i % (h-2);
            check($sformatf("%s x[%0d]", tag, i), res_x[i], ex);
            check($sformatf("%s y[%0d]", tag, i), res_y[i], ey);
            check($sformatf("%s px[%0d]", tag, i), res_px[i], golden(w, ex, ey));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int res_before;
        int t;
        nreset_i     = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        cfg_width_i  = '0;
        cfg_height_i = '0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        repeat (3) tick();

        check("rst busy", busy_o, 0);
        check("rst rd_req", rd_req_o, 0);
        check("rst rd_addr", rd_addr_o, 0);
        check("rst sobel_nreset", sobel_nreset_o, 1);
        check("rst sobel_start", sobel_start_o, 0);
        check("rst px_rdy", sobel_px_rdy_o, 0);
        check("rst out_valid", out_valid_o, 0);
        check("rst frame_done", frame_done_o, 0);
        check("rst cfg_err", cfg_err_o, 0);
        nreset_i = 1'b1;
        tick();

        // 4x4 ramp, zero-latency reads: every window has Gx=8, Gy=32 -> 40.
        clear_logs();
        start_frame(4, 4);
        wait_done(2000, "4x4");
        check("4x4 addr count", addr_log.size(), 24);
        for (int i = 0; i < addr_log.size() && i < 24; i++)
            check($sformatf("4x4 addr[%0d]", i), addr_log[i], exp_addr4[i]);
        check_results(4, 4, "4x4");
        for (int i = 0; i < res_px.size(); i++)
            check($sformatf("4x4 hand px[%0d]", i), res_px[i], 8'h28);
        check("4x4 engine resets", n_nrst_low, 2);
        check("4x4 busy after", busy_o, 0);

        // Flat 5x6 image gives zero gradient everywhere.
        for (int a = 0; a < 256; a++) mem[a] = 8'h80;
        clear_logs();
        start_frame(5, 6);
        wait_done(3000, "5x6");
        check_results(5, 6, "5x6");
        for (int i = 0; i < res_px.size(); i++)
            check($sformatf("5x6 flat px[%0d]", i), res_px[i], 0);
        check("5x6 engine resets", n_nrst_low, 3);

        // Degenerate size: error flag, done two cycles after start, no reads.
        clear_logs();
        cfg_width_i  = 2;
        cfg_height_i = 5;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        check("cfgerr flag", cfg_err_o, 1);
        check("cfgerr done early", frame_done_o, 0);
        check("cfgerr busy", busy_o, 1);
        tick();
        check("cfgerr done", frame_done_o, 1);
        check("cfgerr busy after", busy_o, 0);
        repeat (5) tick();
        check("cfgerr reads", n_rdreq, 0);
        check("cfgerr done count", n_done, 1);
        check("cfgerr sticky", cfg_err_o, 1);
        clear_logs();
        start_frame(4, 4);
        check("cfgerr cleared", cfg_err_o, 0);
        wait_done(2000, "4x4 after err");
        check_results(4, 4, "4x4 after err");

        // 8x8 random image, zero then random read latency.
        for (int a = 0; a < 64; a++) mem[a] = 8'($urandom_range(0, 255));
        rand_delay = 1'b0;
        clear_logs();
        start_frame(8, 8);
        wait_done(4000, "8x8 fast");
        check_results(8, 8, "8x8 fast");
        ref_log = addr_log;
        check("8x8 fast addr count", ref_log.size(), 6*24);
        rand_delay = 1'b1;
        clear_logs();
        start_frame(8, 8);
        wait_done(20000, "8x8 slow");
        check_results(8, 8, "8x8 slow");
        check("8x8 slow addr count", addr_log.size(), ref_log.size());
        for (int i = 0; i < addr_log.size() && i < ref_log.size(); i++)
            check($sformatf("8x8 slow addr[%0d]", i), addr_log[i], ref_log[i]);
        check("8x8 addr stable", n_stab_err, 0);
        rand_delay = 1'b0;
        wait_cnt   = 0;
        repeat (8) tick();

        // Abort just after the first window of strip 1 is pushed.
        clear_logs();
        start_frame(6, 6);
        t = 0;
        while (addr_log.size() < 27 && t < 2000) begin
            tick();
            t++;
        end
        check("abort reads reached", addr_log.size(), 27);
        tick();
        res_before = res_x.size();
        check("abort strip0 results", res_before, 4);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abort rd_req", rd_req_o, 0);
        check("abort sobel_start", sobel_start_o, 0);
        check("abort sobel_nreset", sobel_nreset_o, 0);
        check("abort busy", busy_o, 0);
        tick();
        check("abort sobel_nreset release", sobel_nreset_o, 1);
        repeat (20) tick();
        check("abort late results dropped", res_x.size(), res_before);
        check("abort no frame_done", n_done, 0);
        check("abort idle", busy_o, 0);

        // Full 6x6 afterwards, with a start pulse while busy that must be ignored.
        clear_logs();
        start_frame(6, 6);
        repeat (10) tick();
        check("busy before 2nd start", busy_o, 1);
        start_frame(3, 3);
        wait_done(4000, "6x6");
        check_results(6, 6, "6x6");

        // Asynchronous reset mid-frame.
        clear_logs();
        start_frame(8, 8);
        repeat (30) tick();
        #2;
        nreset_i = 1'b0;
        #1;
        check("async rst busy", busy_o, 0);
        check("async rst rd_req", rd_req_o, 0);
        check("async rst rd_addr", rd_addr_o, 0);
        check("async rst sobel_nreset", sobel_nreset_o, 1);
        check("async rst sobel_start", sobel_start_o, 0);
        check("async rst px_rdy", sobel_px_rdy_o, 0);
        check("async rst out_valid", out_valid_o, 0);
        check("async rst out_x", out_x_o, 0);
        check("async rst frame_done", frame_done_o, 0);
        tick();
        nreset_i = 1'b1;
        tick();
        clear_logs();
        start_frame(4, 4);
        wait_done(2000, "4x4 after rst");
        check_results(4, 4, "4x4 after rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
